// File: rtl/weight_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : weight_fifo_pkg
// Brief    : Shared types and sizing helpers for the weight FIFO drain logic.
// Revision : 1.0
// ============================================================================
package weight_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

    // Cycle counter must reach len + skew span, plus one bit of headroom for compares.
    function automatic int cnt_w(input int depth, input int width);
        return $clog2(depth + width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_fifo_drain_ctrl_gate.sv
`default_nettype none
// ============================================================================
// Module   : fifo_lane_gate
// Brief    : Per-lane pop window: lane pops while off_i <= t < off_i + len_q.
// Revision : 1.0
// ============================================================================
module fifo_lane_gate
    import weight_fifo_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic [CNT_W-1:0] t,
    input  logic [CNT_W-1:0] off_i,
    input  logic [CNT_W-1:0] len_q,
    input  logic             mask_bit,
    input  logic             active,
    output logic             lane_en
);

    logic [CNT_W-1:0] w_end;

    // off_i + len_q never exceeds FIFO_WIDTH-1+FIFO_DEPTH, which CNT_W holds.
    assign w_end   = off_i + len_q;
    assign lane_en = active & mask_bit & (t >= off_i) & (t < w_end);

endmodule
`default_nettype wire

// File: rtl/weight_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weight_fifo_drain_ctrl
// Brief    : Multi-lane weight FIFO drain sequencer with optional diagonal skew.
// Revision : 1.0
// ============================================================================
module weight_fifo_drain_ctrl
    import weight_fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = cnt_w(FIFO_DEPTH, FIFO_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      cfg_len,
    input  logic [FIFO_WIDTH-1:0] cfg_lane_mask,
    input  logic                  cfg_skew,
    input  logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [FIFO_WIDTH-1:0] fifo_en,
    output logic [FIFO_WIDTH-1:0] w_wen
);

    localparam logic [1:0]       c_st_idle  = IDLE;
    localparam logic [1:0]       c_st_drain = DRAIN;
    localparam logic [1:0]       c_st_done  = DONE;
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_skew_ext = CNT_W'(FIFO_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      r_len;
    logic [CNT_W-1:0]      r_t;
    logic [CNT_W-1:0]      w_len_clamp;
    logic [CNT_W-1:0]      w_total;
    logic [FIFO_WIDTH-1:0] r_mask;
    logic [FIFO_WIDTH-1:0] r_wen;
    logic [FIFO_WIDTH-1:0] w_fifo_en;
    logic                  r_skew;
    logic                  r_done;
    logic                  w_active;
    logic                  w_accept;
    logic                  w_last;

    assign w_len_clamp = (cfg_len > c_depth) ? c_depth : cfg_len;
    assign w_total     = r_len + (r_skew ? c_skew_ext : '0);
    assign w_active    = (r_state == c_st_drain) && !stall;
    assign w_accept    = (r_state == c_st_idle) && start;
    assign w_last      = w_active && (r_t == (w_total - c_one));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = (w_len_clamp != '0) ? c_st_drain : c_st_done;
                end
            end
            c_st_drain: begin
                if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_done  <= 1'b0;
            r_wen   <= '0;
            r_len   <= '0;
            r_mask  <= '0;
            r_skew  <= 1'b0;
            r_t     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == c_st_done);
            // Tracks the one-cycle FIFO read latency, so it keeps shifting through stalls.
            r_wen   <= w_fifo_en;
            if (w_accept) begin
                r_len  <= w_len_clamp;
                r_mask <= cfg_lane_mask;
                r_skew <= cfg_skew;
                r_t    <= '0;
            end else if (w_active) begin
                r_t <= r_t + c_one;
            end
        end
    end

    for (genvar gi = 0; gi < FIFO_WIDTH; gi++) begin : g_lane
        localparam logic [CNT_W-1:0] c_lane_off = CNT_W'(gi);
        logic [CNT_W-1:0] w_off;

        assign w_off = r_skew ? c_lane_off : '0;

        fifo_lane_gate #(
            .CNT_W (CNT_W)
        ) u_gate (
            .t        (r_t),
            .off_i    (w_off),
            .len_q    (r_len),
            .mask_bit (r_mask[gi]),
            .active   (w_active),
            .lane_en  (w_fifo_en[gi])
        );
    end

    assign fifo_en = w_fifo_en;
    assign w_wen   = r_wen;
    assign busy    = (r_state != c_st_idle);
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_weight_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_fifo_drain_ctrl
// Brief    : Directed, table-driven bench for weight_fifo_drain_ctrl.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_weight_fifo_drain_ctrl;

    localparam int W  = 16;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] cfg_len;
    logic [W-1:0]  cfg_lane_mask;
    logic          cfg_skew;
    logic          stall;
    logic          busy;
    logic          done;
    logic [W-1:0]  fifo_en;
    logic [W-1:0]  w_wen;

    always #5 clk = ~clk;

    weight_fifo_drain_ctrl #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_len       (cfg_len),
        .cfg_lane_mask (cfg_lane_mask),
        .cfg_skew      (cfg_skew),
        .stall         (stall),
        .busy          (busy),
        .done          (done),
        .fifo_en       (fifo_en),
        .w_wen         (w_wen)
    );

    typedef struct {
        int           len;
        logic [W-1:0] mask;
        bit           skew;
        int           stall_at;
        int           stall_n;
        int           exp_pops;
        int           exp_done;
        int           f0;
        int           l0;
        int           f15;
        int           l15;
    } vec_t;

    vec_t tv[9];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int           pops[W];
        int           wens[W];
        int           first[W];
        int           last[W];
        int           done_k     = -1;
        int           busy_n     = 0;
        int           stall_pops = 0;
        int           trail_err  = 0;
        logic [W-1:0] prev_en    = '0;
        for (int i = 0; i < W; i++) begin
            pops[i] = 0; wens[i] = 0; first[i] = -1; last[i] = -1;
        end
        cfg_len       = CW'(v.len);
        cfg_lane_mask = v.mask;
        cfg_skew      = v.skew;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 80 && done_k < 0; k++) begin
            stall = (k >= v.stall_at) && (k < v.stall_at + v.stall_n);
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (w_wen !== prev_en) trail_err++;
            if (stall && fifo_en !== '0) stall_pops++;
            for (int i = 0; i < W; i++) begin
                if (fifo_en[i] === 1'b1) begin
                    pops[i]++;
                    if (first[i] < 0) first[i] = k;
                    last[i] = k;
                end
                if (w_wen[i] === 1'b1) wens[i]++;
            end
            prev_en = fifo_en;
            if (done === 1'b1) done_k = k;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d done_cycle", id), done_k, v.exp_done);
        check($sformatf("v%0d busy_cycles", id), busy_n, v.exp_done + 1);
        check($sformatf("v%0d wen_trail_errs", id), trail_err, 0);
        check($sformatf("v%0d pops_in_stall", id), stall_pops, 0);
        check($sformatf("v%0d idle_busy", id), busy, 0);
        check($sformatf("v%0d idle_done", id), done, 0);
        check($sformatf("v%0d idle_wen", id), w_wen, 0);
        for (int i = 0; i < W; i++) begin
            check($sformatf("v%0d pops_lane%0d", id, i), pops[i], v.mask[i] ? v.exp_pops : 0);
            check($sformatf("v%0d wens_lane%0d", id, i), wens[i], v.mask[i] ? v.exp_pops : 0);
        end
        check($sformatf("v%0d lane0_first", id), first[0], v.f0);
        check($sformatf("v%0d lane0_last", id), last[0], v.l0);
        check($sformatf("v%0d lane15_first", id), first[15], v.f15);
        check($sformatf("v%0d lane15_last", id), last[15], v.l15);
        @(posedge clk); #1;
    endtask

    initial begin
        int done_k;
        int pops0;
        int dones;

        //          len  mask      skew sa  sn  pops done f0 l0  f15 l15
        tv[0] = '{16, 16'hFFFF, 1'b0, 0, 0, 16, 16,  0, 15,  0, 15};
        tv[1] = '{ 4, 16'hFFFF, 1'b1, 0, 0,  4, 19,  0,  3, 15, 18};
        tv[2] = '{ 8, 16'hFFFF, 1'b0, 5, 3,  8, 11,  0, 10,  0, 10};
        tv[3] = '{ 0, 16'hFFFF, 1'b0, 0, 0,  0,  0, -1, -1, -1, -1};
        tv[4] = '{40, 16'hFFFF, 1'b0, 0, 0, 16, 16,  0, 15,  0, 15};
        tv[5] = '{ 3, 16'h0005, 1'b0, 0, 0,  3,  3,  0,  2, -1, -1};
        tv[6] = '{ 5, 16'h0000, 1'b1, 0, 0,  5, 20, -1, -1, -1, -1};
        tv[7] = '{16, 16'h8001, 1'b1, 0, 0, 16, 31,  0, 15, 15, 30};
        tv[8] = '{ 2, 16'hFFFF, 1'b0, 1, 2,  2,  4,  0,  3,  0,  3};

        rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_lane_mask = '0;
        cfg_skew = 1'b0; stall = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_fifo_en", fifo_en, 0);
        check("reset_wen", w_wen, 0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) run_vec(tv[v], v);

        // Starts during DRAIN and in the DONE cycle are dropped; start right after is taken.
        cfg_len = CW'(4); cfg_lane_mask = 16'hFFFF; cfg_skew = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_k = -1; pops0 = 0;
        for (int k = 0; k < 30 && done_k < 0; k++) begin
            if (k == 1) begin cfg_len = CW'(10); start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            if (fifo_en[0] === 1'b1) pops0++;
            if (done === 1'b1) begin
                done_k = k;
                cfg_len = CW'(3);
                start = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("hs_first_done", done_k, 4);
        check("hs_first_pops", pops0, 4);
        @(negedge clk);
        check("hs_done_start_dropped", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("hs_restart_busy", busy, 1);
        done_k = -1; pops0 = 0;
        for (int k = 0; k < 30 && done_k < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (fifo_en[0] === 1'b1) pops0++;
            if (done === 1'b1) done_k = k;
            @(posedge clk); #1;
        end
        check("hs_second_done", done_k, 3);
        check("hs_second_pops", pops0, 3);
        @(posedge clk); #1;

        // Asynchronous reset at t=7 abandons the drain without a done pulse.
        cfg_len = CW'(16); cfg_lane_mask = 16'hFFFF; cfg_skew = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        #1;
        check("rst_pre_fifo_en", fifo_en, 16'hFFFF);
        rst = 1'b1;
        #1;
        check("rst_async_fifo_en", fifo_en, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_wen", w_wen, 0);
        check("rst_async_done", done, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) dones++;
        end
        check("rst_no_done_after", dones, 0);
        @(posedge clk); #1;
        run_vec(tv[0], 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
